// File: rtl/vga_scan_generator.sv
// 640x480@60 VGA scan timing generator running from the system clock with a
// pixel clock-enable. Produces pixel counters, syncs, active-video and
// image-window flags, plus a frame-buffer read address issued one pixel tick
// ahead of the pixel it belongs to.
module vga_scan_generator #(
    parameter int   PIX_DIV  = 2,
    parameter int   H_TOTAL  = 800,
    parameter int   H_SYNC   = 96,
    parameter int   H_ACT0   = 144,
    parameter int   H_ACT1   = 783,
    parameter int   V_TOTAL  = 525,
    parameter int   V_SYNC   = 2,
    parameter int   V_ACT0   = 35,
    parameter int   V_ACT1   = 514,
    parameter logic SYNC_POL = 1'b1,
    parameter int   WIN_X0   = 270,
    parameter int   WIN_W    = 300,
    parameter int   WIN_Y0   = 52,
    parameter int   WIN_H    = 300,
    parameter int   AW       = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          pix_ce,
    output logic [9:0]    h_count,
    output logic [9:0]    v_count,
    output logic          h_sync,
    output logic          v_sync,
    output logic          active,
    output logic          in_window,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          line_start,
    output logic          frame_start
);

    localparam int PW = $clog2(PIX_DIV);

    localparam logic [PW-1:0] PRE_LAST  = PW'(PIX_DIV - 1);
    localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_SYNC_C  = 10'(H_SYNC);
    localparam logic [9:0]    V_SYNC_C  = 10'(V_SYNC);
    localparam logic [9:0]    H_ACT0_C  = 10'(H_ACT0);
    localparam logic [9:0]    H_ACT1_C  = 10'(H_ACT1);
    localparam logic [9:0]    V_ACT0_C  = 10'(V_ACT0);
    localparam logic [9:0]    V_ACT1_C  = 10'(V_ACT1);
    localparam logic [9:0]    WX0_C     = 10'(WIN_X0);
    localparam logic [9:0]    WX1_C     = 10'(WIN_X0 + WIN_W - 1);
    localparam logic [9:0]    WY0_C     = 10'(WIN_Y0);
    localparam logic [9:0]    WY1_C     = 10'(WIN_Y0 + WIN_H - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(WIN_W * WIN_H - 1);

    logic          run_reg, run_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [9:0]    h_count_reg, h_count_next;
    logic [9:0]    v_count_reg, v_count_next;
    logic          h_sync_reg, h_sync_next;
    logic          v_sync_reg, v_sync_next;
    logic          active_reg, active_next;
    logic          in_window_reg, in_window_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic          mem_rd_reg, mem_rd_next;
    logic          line_start_reg, line_start_next;
    logic          frame_start_reg, frame_start_next;

    // Position one tick ahead and two ticks ahead of the current counters
    logic [9:0]    h1, v1, h2, v2;
    logic          wrap_h, wrap_f;

    // Advance a scan position by one pixel tick, packed as {v, h}
    function automatic logic [19:0] step(input logic [9:0] h, input logic [9:0] v);
        if (h != H_LAST)      return {v, h + 10'd1};
        else if (v != V_LAST) return {v + 10'd1, 10'd0};
        else                  return 20'd0;
    endfunction

    function automatic logic act_at(input logic [9:0] h, input logic [9:0] v);
        return (h >= H_ACT0_C) && (h <= H_ACT1_C) && (v >= V_ACT0_C) && (v <= V_ACT1_C);
    endfunction

    function automatic logic win_at(input logic [9:0] h, input logic [9:0] v);
        return act_at(h, v) && (h >= WX0_C) && (h <= WX1_C) && (v >= WY0_C) && (v <= WY1_C);
    endfunction

    assign pix_ce = (presc_reg == PRE_LAST);

    // Next-state logic: prescaler, counters, decoded outputs and read address
    always_comb begin
        {v1, h1} = step(h_count_reg, v_count_reg);
        {v2, h2} = step(h1, v1);
        wrap_h   = (h_count_reg == H_LAST);
        wrap_f   = wrap_h && (v_count_reg == V_LAST);

        run_next         = en;
        presc_next       = '0;
        h_count_next     = h_count_reg;
        v_count_next     = v_count_reg;
        h_sync_next      = h_sync_reg;
        v_sync_next      = v_sync_reg;
        active_next      = active_reg;
        in_window_next   = in_window_reg;
        mem_addr_next    = mem_addr_reg;
        mem_rd_next      = mem_rd_reg;
        line_start_next  = 1'b0;
        frame_start_next = 1'b0;

        if (!en) begin
            h_count_next   = '0;
            v_count_next   = '0;
            h_sync_next    = ~SYNC_POL;
            v_sync_next    = ~SYNC_POL;
            active_next    = 1'b0;
            in_window_next = 1'b0;
            mem_addr_next  = '0;
            mem_rd_next    = 1'b0;
        end else begin
            // The first enabled clock only restarts the prescaler at zero
            if (run_reg && (presc_reg != PRE_LAST)) begin
                presc_next = presc_reg + PW'(1);
            end
            if (pix_ce) begin
                h_count_next     = h1;
                v_count_next     = v1;
                line_start_next  = wrap_h;
                frame_start_next = wrap_f;
                // Decode from the values being loaded so flags line up with the counters
                h_sync_next      = (h1 < H_SYNC_C) ? SYNC_POL : ~SYNC_POL;
                v_sync_next      = (v1 < V_SYNC_C) ? SYNC_POL : ~SYNC_POL;
                active_next      = act_at(h1, v1);
                in_window_next   = win_at(h1, v1);
                // Address targets the position after next, so it leads in_window by one tick
                if (win_at(h2, v2)) begin
                    mem_rd_next = 1'b1;
                    if ((h2 == WX0_C) && (v2 == WY0_C)) begin
                        mem_addr_next = '0;
                    end else if (mem_addr_reg != ADDR_LAST) begin
                        mem_addr_next = mem_addr_reg + AW'(1);
                    end
                end else begin
                    mem_rd_next = 1'b0;
                    if (wrap_f) begin
                        mem_addr_next = '0;
                    end
                end
            end
        end
    end

    // State register with asynchronous active-low reset to idle values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_reg         <= 1'b0;
            presc_reg       <= '0;
            h_count_reg     <= '0;
            v_count_reg     <= '0;
            h_sync_reg      <= ~SYNC_POL;
            v_sync_reg      <= ~SYNC_POL;
            active_reg      <= 1'b0;
            in_window_reg   <= 1'b0;
            mem_addr_reg    <= '0;
            mem_rd_reg      <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            run_reg         <= run_next;
            presc_reg       <= presc_next;
            h_count_reg     <= h_count_next;
            v_count_reg     <= v_count_next;
            h_sync_reg      <= h_sync_next;
            v_sync_reg      <= v_sync_next;
            active_reg      <= active_next;
            in_window_reg   <= in_window_next;
            mem_addr_reg    <= mem_addr_next;
            mem_rd_reg      <= mem_rd_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign h_count     = h_count_reg;
    assign v_count     = v_count_reg;
    assign h_sync      = h_sync_reg;
    assign v_sync      = v_sync_reg;
    assign active      = active_reg;
    assign in_window   = in_window_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_rd      = mem_rd_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule
